// File: rtl/dvs_event_buffer_ctrl.sv
// Circular-buffer controller in front of a single-port SRAM: event words go in on
// one valid/ready stream and come back out in FIFO order on another.
module dvs_event_buffer_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [WIDTH-1:0]           s_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [WIDTH-1:0]           m_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       sram_ce,
   output logic                       sram_we,
   output logic [$clog2(DEPTH)-1:0]   sram_addr,
   output logic [WIDTH/8-1:0]         sram_wmask,
   output logic [WIDTH-1:0]           sram_wdata,
   input  logic [WIDTH-1:0]           sram_rdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned MW = WIDTH / 8;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          m_valid_q, m_valid_d;
   logic          prio_q, prio_d;

   logic          full;
   logic          rd_want;
   logic          wr_fire;
   logic          rd_fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         m_valid_q <= 1'b0;
         prio_q    <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         m_valid_q <= m_valid_d;
         prio_q    <= prio_d;
      end
   end

   // Port arbitration: a read is only worth issuing if the output slot will be free,
   // and prio flips on every contested cycle so reads and writes alternate.
   always_comb begin
      full    = (count_q == CW'(DEPTH));
      rd_want = (count_q != '0) && (!m_valid_q || m_ready);
      s_ready = !full && !flush && !(rd_want && prio_q);
      wr_fire = s_valid && s_ready;
      rd_fire = rd_want && !flush && !wr_fire;

      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      m_valid_d = m_valid_q;
      prio_d    = prio_q;

      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         m_valid_d = 1'b0;
         prio_d    = 1'b0;
      end else begin
         if (s_valid && rd_want && !full) begin
            prio_d = !prio_q;
         end
         if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(wr_fire) - CW'(rd_fire);
         if (rd_fire) begin
            m_valid_d = 1'b1;
         end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
         end
      end
   end

   // SRAM read data is registered inside the macro, so it lines up with m_valid_q.
   assign sram_ce    = wr_fire || rd_fire;
   assign sram_we    = wr_fire;
   assign sram_addr  = wr_fire ? wr_ptr_q : rd_ptr_q;
   assign sram_wmask = {MW{1'b1}};
   assign sram_wdata = s_data;

   assign m_valid = m_valid_q;
   assign m_data  = sram_rdata;
   assign level   = count_q;

endmodule

// File: tb/tb_dvs_event_buffer_ctrl.sv
// Bench for dvs_event_buffer_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dvs_event_buffer_ctrl;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic [AW:0]      level;
   logic             sram_ce;
   logic             sram_we;
   logic [AW-1:0]    sram_addr;
   logic [WIDTH/8-1:0] sram_wmask;
   logic [WIDTH-1:0] sram_wdata;
   logic [WIDTH-1:0] sram_rdata;

   dvs_event_buffer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .level(level),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   // Single-port SRAM macro model with registered read data.
   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) mem[sram_addr] <= sram_wdata;
         else         sram_rdata <= mem[sram_addr];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words stored but not yet read, the word on the output, and op counts.
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] got[$];
   logic             mdl_mv = 1'b0;
   logic [WIDTH-1:0] mdl_mw = '0;
   logic             mdl_prio = 1'b0;
   int               wcnt = 0;
   int               rcnt = 0;

   always @(negedge clk) begin
      logic want, exp_rdy, wf, rf;
      if (rst) begin
         q.delete();
         mdl_mv = 1'b0; mdl_prio = 1'b0; wcnt = 0; rcnt = 0;
         chk("rst_level", 32'(level), 32'd0);
         chk("rst_m_valid", 32'(m_valid), 32'd0);
      end else begin
         chk("level", 32'(level), 32'(q.size()));
         chk("m_valid", 32'(m_valid), 32'(mdl_mv));
         if (mdl_mv) chk("m_data", 32'(m_data), 32'(mdl_mw));
         want    = (q.size() > 0) && (!mdl_mv || m_ready);
         exp_rdy = (q.size() < DEPTH) && !flush && !(want && mdl_prio);
         wf      = s_valid && exp_rdy;
         rf      = want && !flush && !wf;
         chk("s_ready", 32'(s_ready), 32'(exp_rdy));
         chk("sram_ce", 32'(sram_ce), 32'(wf || rf));
         chk("sram_we", 32'(sram_we), 32'(wf));
         if (wf) begin
            chk("wr_addr", 32'(sram_addr), 32'(wcnt % DEPTH));
            chk("wdata", 32'(sram_wdata), 32'(s_data));
            chk("wmask", 32'(sram_wmask), 32'h3);
         end
         if (rf) chk("rd_addr", 32'(sram_addr), 32'(rcnt % DEPTH));
         if (flush) begin
            q.delete();
            mdl_mv = 1'b0; mdl_prio = 1'b0; wcnt = 0; rcnt = 0;
         end else begin
            if (s_valid && want && q.size() < DEPTH) mdl_prio = !mdl_prio;
            if (mdl_mv && m_ready) got.push_back(mdl_mw);
            if (wf) begin
               q.push_back(s_data);
               wcnt++;
            end
            if (rf) begin
               mdl_mw = q.pop_front();
               mdl_mv = 1'b1;
               rcnt++;
            end else if (mdl_mv && m_ready) begin
               mdl_mv = 1'b0;
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      bit done = 0;
      s_valid = 1'b1;
      s_data  = w;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (s_ready) done = 1;
      end
      if (!done) chk("push_timeout", 32'd0, 32'd1);
      cyc(1);
      s_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
   endtask

   task automatic wait_mvalid(input string name);
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (m_valid) seen = 1;
      end
      if (!seen) chk(name, 32'd0, 32'd1);
   endtask

   initial begin
      logic we_seq [6];
      int   base;
      rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      cyc(2);
      rst = 1'b0;
      @(negedge clk);
      chk("init_level", 32'(level), 32'd0);
      chk("init_s_ready", 32'(s_ready), 32'd1);
      chk("init_ce", 32'(sram_ce), 32'd0);
      chk("init_m_valid", 32'(m_valid), 32'd0);
      cyc(1);

      // Fill: first word lands on the output, the next 16 fill the SRAM.
      for (int i = 0; i < 17; i++) push(WIDTH'(16'h0100 + i));
      @(negedge clk);
      chk("full_level", 32'(level), 32'd16);
      chk("full_s_ready", 32'(s_ready), 32'd0);
      chk("full_m_data", 32'(m_data), 32'h0100);
      cyc(1);
      got.delete();
      m_ready = 1'b1;
      cyc(20);
      m_ready = 1'b0;
      chk("drain_count", 32'(got.size()), 32'd17);
      for (int i = 0; i < 17 && i < got.size(); i++) chk("drain_word", 32'(got[i]), 32'h0100 + 32'(i));
      chk("drain_level", 32'(level), 32'd0);

      // Wrap-around rounds.
      for (int r = 0; r < 3; r++) begin
         got.delete();
         base = 16'h2000 + r * 16;
         for (int i = 0; i < 10; i++) push(WIDTH'(base + i));
         m_ready = 1'b1;
         cyc(14);
         m_ready = 1'b0;
         chk("wrap_count", 32'(got.size()), 32'd10);
         for (int i = 0; i < 10 && i < got.size(); i++) chk("wrap_word", 32'(got[i]), 32'(base + i));
      end

      // Contention from a clean state: write, then strict alternation.
      do_flush();
      s_valid = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_data = WIDTH'(16'h3000 + i);
         @(negedge clk);
         if (i < 6) we_seq[i] = sram_we;
         cyc(1);
      end
      s_valid = 1'b0;
      cyc(5);
      m_ready = 1'b0;
      chk("cont_we0", 32'(we_seq[0]), 32'd1);
      chk("cont_we1", 32'(we_seq[1]), 32'd1);
      chk("cont_we2", 32'(we_seq[2]), 32'd0);
      chk("cont_we3", 32'(we_seq[3]), 32'd1);
      chk("cont_we4", 32'(we_seq[4]), 32'd0);
      chk("cont_we5", 32'(we_seq[5]), 32'd1);

      // Downstream stall with writes behind it.
      do_flush();
      push(16'hBEEF);
      cyc(3);
      @(negedge clk);
      chk("stall_m_valid", 32'(m_valid), 32'd1);
      chk("stall_m_data0", 32'(m_data), 32'hBEEF);
      chk("stall_level0", 32'(level), 32'd0);
      cyc(1);
      for (int i = 0; i < 5; i++) begin
         s_valid = (i % 2 == 0);
         s_data  = WIDTH'(16'h4000 + i);
         cyc(1);
      end
      s_valid = 1'b0;
      @(negedge clk);
      chk("stall_m_data1", 32'(m_data), 32'hBEEF);
      chk("stall_level1", 32'(level), 32'd3);
      cyc(1);

      // Flush with a stalled word and seven stored words.
      for (int i = 0; i < 4; i++) push(WIDTH'(16'h5000 + i));
      @(negedge clk);
      chk("pre_flush_level", 32'(level), 32'd7);
      cyc(1);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_ce", 32'(sram_ce), 32'd0);
      chk("flush_s_ready", 32'(s_ready), 32'd0);
      cyc(1);
      flush = 1'b0;
      @(negedge clk);
      chk("post_flush_level", 32'(level), 32'd0);
      chk("post_flush_m_valid", 32'(m_valid), 32'd0);
      chk("post_flush_s_ready", 32'(s_ready), 32'd1);
      cyc(1);
      push(16'h0A0A);
      m_ready = 1'b1;
      wait_mvalid("flush_readback_timeout");
      chk("flush_readback", 32'(m_data), 32'h0A0A);
      cyc(3);
      m_ready = 1'b0;

      // Asynchronous reset in the middle of a read burst.
      do_flush();
      for (int i = 0; i < 8; i++) push(WIDTH'(16'h6000 + i));
      m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_m_valid", 32'(m_valid), 32'd0);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_ce", 32'(sram_ce), 32'd0);
      cyc(2);
      rst = 1'b0;
      m_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
      chk("post_rst_level", 32'(level), 32'd0);
      cyc(1);
      push(16'h1234);
      m_ready = 1'b1;
      wait_mvalid("post_rst_timeout");
      chk("post_rst_word", 32'(m_data), 32'h1234);
      cyc(3);
      m_ready = 1'b0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
